// File: rtl/snake_renderer.sv
// snake_renderer: segment store for a snake game plus a two-stage pixel
// colour pipeline.
//   Clk, Reset          pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank current pixel and active-video flag
//   frame_start         pulse at start of vertical blank (move commit point)
//   move, grow, head_*  move request with new head position and grow flag
//   food_x, food_y      food centre
//   Red, Green, Blue    registered pixel colour, 2 cycles after the pixel
//   length, busy        segment count, move in progress
//   self_hit            sticky head-on-body collision flag
module snake_renderer #(
    parameter int unsigned MAX_SEG  = 32,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned SIZE     = 4,
    parameter int unsigned START_X  = 320,
    parameter int unsigned START_Y  = 240,
    parameter int unsigned STEP     = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic       frame_start,
    input  logic       move,
    input  logic       grow,
    input  logic [9:0] head_x,
    input  logic [9:0] head_y,
    input  logic [9:0] food_x,
    input  logic [9:0] food_y,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic [6:0] length,
    output logic       busy,
    output logic       self_hit
);

    localparam int unsigned CW    = 10;
    localparam int unsigned LEN_W = 7;
    localparam int unsigned IDX_W = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;

    typedef enum logic [1:0] {IDLE, PENDING, SHIFT, CHECK} state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      seg_x [MAX_SEG];
    logic [CW-1:0]      seg_y [MAX_SEG];
    logic [CW-1:0]      lat_x;
    logic [CW-1:0]      lat_y;
    logic               lat_grow;
    logic [LEN_W-1:0]   chk_idx;
    logic               check_last_c;
    logic               latch_en_c;
    logic               shift_en_c;
    logic               check_en_c;
    logic               chk_match_c;

    // Distance test |p - c| <= SIZE in 11 bits, no wrap-around.
    function automatic logic near(input logic [CW-1:0] p, input logic [CW-1:0] c);
        logic [CW:0] d;
        if (p >= c) d = {1'b0, p} - {1'b0, c};
        else        d = {1'b0, c} - {1'b0, p};
        return d <= (CW+1)'(SIZE);
    endfunction

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Last scan index reached (length==1 still spends one CHECK cycle)
    assign check_last_c = (chk_idx >= (length - LEN_W'(1)));

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (move)        state_next = PENDING;
            PENDING: if (frame_start) state_next = SHIFT;
            SHIFT:                    state_next = CHECK;
            CHECK:   if (check_last_c) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        latch_en_c = 1'b0;
        shift_en_c = 1'b0;
        check_en_c = 1'b0;
        case (state)
            IDLE:    latch_en_c = move;
            SHIFT:   shift_en_c = 1'b1;
            CHECK:   check_en_c = (chk_idx < length);
            default: ;
        endcase
    end

    assign chk_match_c = (seg_x[IDX_W'(chk_idx)] == seg_x[0]) &&
                         (seg_y[IDX_W'(chk_idx)] == seg_y[0]);

    // Move latch, segment shift, length and collision scan
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(MAX_SEG); i++) begin
                seg_x[i] <= CW'(int'(START_X) - i * int'(STEP));
                seg_y[i] <= CW'(START_Y);
            end
            lat_x    <= '0;
            lat_y    <= '0;
            lat_grow <= 1'b0;
            length   <= LEN_W'(INIT_LEN);
            chk_idx  <= LEN_W'(1);
            busy     <= 1'b0;
            self_hit <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            if (latch_en_c) begin
                lat_x    <= head_x;
                lat_y    <= head_y;
                lat_grow <= grow;
            end
            if (shift_en_c) begin
                for (int i = int'(MAX_SEG) - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= lat_x;
                seg_y[0] <= lat_y;
                if (lat_grow && (length < LEN_W'(MAX_SEG)))
                    length <= length + LEN_W'(1);
                chk_idx <= LEN_W'(1);
            end
            if (state == CHECK)
                chk_idx <= chk_idx + LEN_W'(1);
            if (check_en_c && chk_match_c)
                self_hit <= 1'b1;
        end
    end

    // Render stage 1: pixel coordinate and blank
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic          b1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x1 <= '0;
            y1 <= '0;
            b1 <= 1'b0;
        end else begin
            x1 <= DrawX;
            y1 <= DrawY;
            b1 <= blank;
        end
    end

    // Hit tests on stage-1 coordinates against live storage
    logic head_hit_c;
    logic body_hit_c;
    logic food_hit_c;

    always_comb begin
        head_hit_c = near(x1, seg_x[0]) && near(y1, seg_y[0]);
        food_hit_c = near(x1, food_x) && near(y1, food_y);
        body_hit_c = 1'b0;
        for (int i = 1; i < int'(MAX_SEG); i++) begin
            if ((LEN_W'(i) < length) && near(x1, seg_x[i]) && near(y1, seg_y[i]))
                body_hit_c = 1'b1;
        end
    end

    // Render stage 2: colour by priority
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Red   <= 8'h00;
            Green <= 8'h00;
            Blue  <= 8'h00;
        end else if (!b1) begin
            Red   <= 8'h00;
            Green <= 8'h00;
            Blue  <= 8'h00;
        end else if (head_hit_c) begin
            Red   <= 8'h00;
            Green <= 8'h80;
            Blue  <= 8'hFF;
        end else if (body_hit_c) begin
            Red   <= 8'h00;
            Green <= 8'h00;
            Blue  <= 8'hFF;
        end else if (food_hit_c) begin
            Red   <= 8'hFF;
            Green <= 8'h00;
            Blue  <= 8'h00;
        end else begin
            Red   <= 8'h00;
            Green <= 8'h7F - {1'b0, y1[9:3]};
            Blue  <= 8'h00;
        end
    end

endmodule
